// File: rtl/i_cache_assoc_if.sv
// Fetch-side and refill-side signals of the instruction cache, bundled as one bus.
// The cache takes the slave view; the fetch stage/memory pair (or a bench) takes the master view.
interface i_cache_assoc_if #(
  parameter int XLEN       = 32,
  parameter int BLOCK_SIZE = 4
);
  logic [BLOCK_SIZE*32-1:0] i_DataBlock;
  logic                     i_MemReady;
  logic                     o_DataReq;
  logic [XLEN-1:0]          o_MemAddr;
  logic [XLEN-1:0]          i_Addr;
  logic                     i_Flush;
  logic [31:0]              o_Data;
  logic                     o_Stall;

  modport slave (
    input  i_DataBlock, i_MemReady, i_Addr, i_Flush,
    output o_DataReq, o_MemAddr, o_Data, o_Stall
  );

  modport master (
    output i_DataBlock, i_MemReady, i_Addr, i_Flush,
    input  o_DataReq, o_MemAddr, o_Data, o_Stall
  );
endinterface

// File: rtl/i_cache_assoc.sv
// 1/2-way set-associative instruction cache with whole-block refill,
// per-set LRU and a sequential set-by-set flush for fence.i.
module i_cache_assoc #(
  parameter int XLEN       = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int ENTRIES    = 64,
  parameter int WAYS       = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  i_cache_assoc_if.slave bus
);
  localparam int M   = $clog2(BLOCK_SIZE);
  localparam int N   = $clog2(ENTRIES);
  localparam int TAG = XLEN - N - M - 2;
  localparam logic [N-1:0] LAST_SET = N'(ENTRIES - 1);

  typedef enum logic [1:0] {COMPARE, ALLOCATE, FLUSH} state_t;

  state_t                   state;
  logic                     data_req;
  logic                     flush_pending;
  logic [N-1:0]             cnt;
  logic [WAYS-1:0][ENTRIES-1:0] valid;
  logic [ENTRIES-1:0]       lru;
  logic [TAG-1:0]           tag_mem  [WAYS][ENTRIES];
  logic [BLOCK_SIZE*32-1:0] data_mem [WAYS][ENTRIES];

  logic [N-1:0]             index;
  logic [TAG-1:0]           tag;
  logic                     hit0;
  logic                     hit1;
  logic                     hit;
  logic                     hit_way;
  logic                     victim;
  logic                     refill;
  logic [BLOCK_SIZE*32-1:0] line;
  logic [31:0]              word;

  assign index = bus.i_Addr[M+2 +: N];
  assign tag   = bus.i_Addr[M+N+2 +: TAG];

  always_comb begin
    hit0    = valid[0][index] && (tag_mem[0][index] == tag);
    hit1    = (WAYS == 2) && valid[WAYS-1][index] && (tag_mem[WAYS-1][index] == tag);
    hit     = hit0 || hit1;
    hit_way = !hit0;
    line    = hit0 ? data_mem[0][index] : data_mem[WAYS-1][index];
  end

  // Victim: first invalid way (way 0 first), otherwise whichever way LRU points at.
  always_comb begin
    victim = 1'b0;
    if (WAYS == 2) begin
      if (!valid[0][index])
        victim = 1'b0;
      else if (!valid[WAYS-1][index])
        victim = 1'b1;
      else
        victim = lru[index];
    end
  end

  generate
    if (M > 0) begin : g_offset
      logic [M-1:0] offset;
      assign offset = bus.i_Addr[M+1:2];
      assign word   = line[{offset, 5'b0} +: 32];
    end else begin : g_no_offset
      assign word = line[31:0];
    end
  endgenerate

  assign refill = (state == ALLOCATE) && bus.i_MemReady;

  assign bus.o_Stall   = (state != COMPARE) || !hit || bus.i_Flush;
  assign bus.o_Data    = bus.o_Stall ? 32'h0 : word;
  assign bus.o_DataReq = data_req;
  assign bus.o_MemAddr = {bus.i_Addr[XLEN-1:M+2], {(M+2){1'b0}}};

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state         <= COMPARE;
      data_req      <= 1'b0;
      flush_pending <= 1'b0;
      cnt           <= '0;
      valid         <= '0;
      lru           <= '0;
    end else begin
      case (state)
        COMPARE: begin
          if (bus.i_Flush) begin
            state <= FLUSH;
            cnt   <= '0;
          end else if (hit) begin
            lru[index] <= !hit_way;
          end else begin
            state    <= ALLOCATE;
            data_req <= 1'b1;
          end
        end
        ALLOCATE: begin
          if (bus.i_Flush)
            flush_pending <= 1'b1;
          if (bus.i_MemReady) begin
            for (int w = 0; w < WAYS; w++)
              if (victim == 1'(w))
                valid[w][index] <= 1'b1;
            lru[index] <= !victim;
            data_req   <= 1'b0;
            cnt        <= '0;
            // A flush that arrives on the refill beat itself must not be lost.
            state      <= (flush_pending || bus.i_Flush) ? FLUSH : COMPARE;
          end
        end
        FLUSH: begin
          for (int w = 0; w < WAYS; w++)
            valid[w][cnt] <= 1'b0;
          lru[cnt] <= 1'b0;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST_SET) begin
            state         <= COMPARE;
            flush_pending <= 1'b0;
          end
        end
        default: begin
          state    <= COMPARE;
          data_req <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge i_clk) begin
    if (refill) begin
      for (int w = 0; w < WAYS; w++) begin
        if (victim == 1'(w)) begin
          tag_mem[w][index]  <= tag;
          data_mem[w][index] <= bus.i_DataBlock;
        end
      end
    end
  end
endmodule
